hex_area_acc: RTL
=================

Name: hex_area_acc

Overview:
- Sits directly downstream of the angular-sort stage in the geofence datapath.
- Consumes the six angle-ordered hexagon vertices and that stage's one-cycle done pulse.
- Computes twice the hexagon area with the shoelace formula, one cross term per clock. The result feeds the later inside/outside comparison stage.
- The result is unsigned and is valid for either vertex winding direction.

Parameters:
- COORD_W, 10: width of each unsigned coordinate. A vertex is {x, y}, 2*COORD_W bits wide.
- ACC_W, 24: signed accumulator width. Must be at least 2*COORD_W+4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle pulse; driven by the sort stage's finish_sort
- G1..G6  input  2*COORD_W each  sorted vertices; x is [2*COORD_W-1:COORD_W], y is [COORD_W-1:0]
- area2  output  2*COORD_W+1  |2 x polygon area|, registered
- area_valid  output  1  one-cycle pulse when area2 is updated
- busy  output  1  high from the cycle after start is accepted through the DONE cycle

Behaviour:
- Reset (reset=0, asynchronous) forces: state=IDLE, idx=0, acc=0, the vertex snapshot regs P0..P5=0, area2=0, area_valid=0, busy=0. Deasserting reset mid-operation does not resume the aborted run; no area_valid is produced for it.
- States:
  - IDLE: busy=0. On an edge with start=1: latch G1..G6 into P0..P5, set acc=0 and idx=0, go to ACC. start=0 stays in IDLE.
  - ACC: busy=1. Each edge adds term(idx) to acc and increments idx. When idx==5, the edge instead loads area2 with |acc + term(5)| (low 2*COORD_W+1 bits), sets area_valid=1 and goes to DONE.
  - DONE: busy=1, area_valid=1 for exactly this cycle. Next edge goes to IDLE with area_valid=0.
- term(i) = x(Pi)*y(P(i+1 mod 6)) - x(P(i+1 mod 6))*y(Pi):
  - each product is an unsigned 2*COORD_W-bit value;
  - the difference is a signed 2*COORD_W+1-bit value, sign-extended to ACC_W;
  - P5 wraps to P0.
- Absolute value is taken on the full ACC_W sum; for COORD_W=10 the maximum is 2*1023^2 = 2093058, which fits in 21 bits.
- Timing:
  - start=1 in cycle 0 is sampled at the edge ending cycle 0.
  - ACC occupies cycles 1-6.
  - area_valid=1 and the new area2 appear in cycle 7.
  - busy is high in cycles 1-7.
- start is ignored while in ACC or DONE. The snapshot is taken only in IDLE, so changes on G1..G6 during a run do not affect the result.
- area2 holds its value between runs and is overwritten only at the next completion.
- Degenerate inputs (collinear or identical vertices) give a legitimate 0.
- No internal timeout and no other outputs.

Test Plan:
- Reset low then high, no start -> area2=0, area_valid=0, busy=0 held for 20 cycles.
- Vertices (2,0),(6,0),(8,3),(6,6),(2,6),(0,3), start pulse in cycle 0 -> busy=1 in cycles 1-7; area_valid=1 only in cycle 7; area2=72.
- Same six points in reversed order -> area2=72 (winding independence).
- Extreme square (0,0),(1023,0),(1023,512),(1023,1023),(0,1023),(0,512) -> area2=2093058, no overflow.
- All six vertices = (300,300) -> area2=0 with area_valid pulse. Then, during a new run, a second start in cycle 3 and changed G inputs -> ignored: single area_valid in cycle 7, result computed from the snapshot.
- Start the hexagon run, assert reset=0 in cycle 4, release, no further start -> no area_valid; area2=0, busy=0. A new start afterwards -> area2=72 in cycle 7 relative to that start.

Source files
------------

// File: rtl/hex_area_acc.sv
// Twice-area of a six-vertex polygon via the shoelace formula, one cross term per clock.
// Vertices are snapshotted at start so the upstream sort stage may move on immediately.
module hex_area_acc #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned ACC_W   = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [2*COORD_W-1:0]   G1,
   input  logic [2*COORD_W-1:0]   G2,
   input  logic [2*COORD_W-1:0]   G3,
   input  logic [2*COORD_W-1:0]   G4,
   input  logic [2*COORD_W-1:0]   G5,
   input  logic [2*COORD_W-1:0]   G6,
   output logic [2*COORD_W:0]     area2,
   output logic                   area_valid,
   output logic                   busy
);

   localparam int unsigned VW     = 2 * COORD_W;
   localparam int unsigned TERM_W = 2 * COORD_W + 1;
   localparam int unsigned IDX_W  = 3;

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                    state, state_nx;
   logic [IDX_W-1:0]          idx, idx_nx;
   logic signed [ACC_W-1:0]   acc, acc_nx;
   logic [VW-1:0]             p    [6];
   logic [VW-1:0]             p_nx [6];
   logic [TERM_W-1:0]         area2_nx;
   logic                      area_valid_nx;
   logic                      busy_nx;

   logic [VW-1:0]             cur_v, nxt_v;
   logic [COORD_W-1:0]        xa, ya, xb, yb;
   logic [VW-1:0]             prod_a, prod_b;
   logic signed [TERM_W-1:0]  term;
   logic signed [ACC_W-1:0]   term_ext, sum, abs_sum;

   // Cross term for the current edge; vertex 5 wraps back to vertex 0
   always_comb begin
      cur_v    = p[idx];
      nxt_v    = (idx == IDX_W'(5)) ? p[0] : p[IDX_W'(idx + IDX_W'(1))];
      xa       = cur_v[VW-1:COORD_W];
      ya       = cur_v[COORD_W-1:0];
      xb       = nxt_v[VW-1:COORD_W];
      yb       = nxt_v[COORD_W-1:0];
      prod_a   = VW'(xa) * VW'(yb);
      prod_b   = VW'(xb) * VW'(ya);
      term     = $signed({1'b0, prod_a}) - $signed({1'b0, prod_b});
      term_ext = {{(ACC_W-TERM_W){term[TERM_W-1]}}, term};
      sum      = acc + term_ext;
      abs_sum  = sum[ACC_W-1] ? -sum : sum;
   end

   always_comb begin
      state_nx      = state;
      idx_nx        = idx;
      acc_nx        = acc;
      p_nx          = p;
      area2_nx      = area2;
      area_valid_nx = 1'b0;
      busy_nx       = busy;
      case (state)
         IDLE: begin
            busy_nx = 1'b0;
            if (start) begin
               p_nx[0]  = G1;
               p_nx[1]  = G2;
               p_nx[2]  = G3;
               p_nx[3]  = G4;
               p_nx[4]  = G5;
               p_nx[5]  = G6;
               acc_nx   = '0;
               idx_nx   = '0;
               busy_nx  = 1'b1;
               state_nx = ACC;
            end
         end
         ACC: begin
            if (idx == IDX_W'(5)) begin
               area2_nx      = TERM_W'(abs_sum);
               area_valid_nx = 1'b1;
               state_nx      = DONE;
            end else begin
               acc_nx = sum;
               idx_nx = IDX_W'(idx + IDX_W'(1));
            end
         end
         DONE: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         acc        <= '0;
         for (int i = 0; i < 6; i++) p[i] <= '0;
         area2      <= '0;
         area_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         acc        <= acc_nx;
         p          <= p_nx;
         area2      <= area2_nx;
         area_valid <= area_valid_nx;
         busy       <= busy_nx;
      end
   end

endmodule
